exec_control_unit: RTL and testbench

Instruction decode, ALU and slow-clock generation slice of the 8-bit, 4-register teaching CPU.
- Divides the board oscillator into the CPU step clock.
- Decodes the 2-bit opcode into datapath control strobes.
- Produces the sign-extended immediate, the register write-address select and the 8-bit ALU sum.
- Register file, data memory, PC and 7-segment display sit outside this block and consume its outputs.

---
 rtl/exec_control_unit.sv | 100 ++++++++++
 tb/tb_exec_control_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_control_unit.sv
// Decode, adder and step-clock divider slice of the 8-bit teaching CPU.
// Control and datapath outputs are purely combinational on the inputs.
module exec_control_unit #(
  parameter int HALF_PERIOD = 25000000,
  parameter int CNT_W       = 32
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] instruction,
  input  logic [7:0] reg_data1,
  input  logic [7:0] reg_data2,
  output logic       clk_out,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src,
  output logic       branch,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       alu_op,
  output logic [7:0] imm,
  output logic [1:0] write_reg,
  output logic [7:0] alu_result
);

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_JUMP  = 2'b11
  } opcode_e;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  opcode_e          op;
  logic [1:0]       rt;
  logic [1:0]       rd;
  logic [7:0]       operand2;

  assign wrap = (cnt == CNT_LAST);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (wrap) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

  assign op = opcode_e'(instruction[7:6]);
  assign rt = instruction[3:2];
  assign rd = instruction[1:0];

  always_comb begin
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 1'b0;
    unique case (op)
      OP_ADD: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        alu_op    = 1'b1;
      end
      OP_LOAD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_JUMP: begin
        branch = 1'b1;
      end
      default: ;
    endcase
  end

  // two-bit immediate field gives the -2..+1 offset range
  assign imm = {{6{instruction[1]}}, instruction[1:0]};

  assign write_reg  = reg_dst ? rd : rt;
  assign operand2   = alu_src ? imm : reg_data2;
  assign alu_result = reg_data1 + operand2;

endmodule

// File: tb/tb_exec_control_unit.sv
// Bench for exec_control_unit: divider timing, decode table,
// datapath directed cases and randomized instructions.
module tb_exec_control_unit;

  localparam int HP = 2;

  logic       clk_in = 1'b0;
  logic       reset;
  logic [7:0] instruction;
  logic [7:0] reg_data1;
  logic [7:0] reg_data2;
  logic       clk_out;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src;
  logic       branch;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       alu_op;
  logic [7:0] imm;
  logic [1:0] write_reg;
  logic [7:0] alu_result;

  int tests_run = 0;
  int tests_failed = 0;

  exec_control_unit #(.HALF_PERIOD(HP), .CNT_W(8)) dut (
    .clk_in(clk_in),
    .reset(reset),
    .instruction(instruction),
    .reg_data1(reg_data1),
    .reg_data2(reg_data2),
    .clk_out(clk_out),
    .reg_dst(reg_dst),
    .reg_write(reg_write),
    .alu_src(alu_src),
    .branch(branch),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_to_reg(mem_to_reg),
    .alu_op(alu_op),
    .imm(imm),
    .write_reg(write_reg),
    .alu_result(alu_result)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ctrl_vec();
    return {reg_dst, reg_write, alu_src, branch,
            mem_read, mem_write, mem_to_reg, alu_op};
  endfunction

  // Reference: control table, immediate and sum from the opcode rules
  function automatic logic [7:0] ref_ctrl(input logic [7:0] ins);
    logic [7:0] tbl [4];
    tbl[0] = 8'b11000001;
    tbl[1] = 8'b01101010;
    tbl[2] = 8'b00100100;
    tbl[3] = 8'b00010000;
    return tbl[ins[7:6]];
  endfunction

  function automatic logic [7:0] ref_imm(input logic [7:0] ins);
    int v;
    v = int'(ins[1:0]);
    if (v >= 2) v = v - 4;
    return 8'((v + 256) % 256);
  endfunction

  function automatic logic [1:0] ref_wreg(input logic [7:0] ins);
    return (ins[7:6] == 2'd0) ? ins[1:0] : ins[3:2];
  endfunction

  function automatic logic [7:0] ref_sum(input logic [7:0] ins,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    int op2;
    int s;
    op2 = (ins[7:6] == 2'd1 || ins[7:6] == 2'd2)
          ? int'(ref_imm(ins)) : int'(b);
    s = (int'(a) + op2) % 256;
    return 8'(s);
  endfunction

  task automatic check_comb(input string name);
    logic [7:0] ec;
    logic [7:0] ei;
    logic [1:0] ew;
    logic [7:0] es;
    ec = ref_ctrl(instruction);
    ei = ref_imm(instruction);
    ew = ref_wreg(instruction);
    es = ref_sum(instruction, reg_data1, reg_data2);
    tests_run++;
    if (ctrl_vec() !== ec || imm !== ei ||
        write_reg !== ew || alu_result !== es) begin
      tests_failed++;
      $display("FAIL %s ins=%h d1=%h d2=%h got ctrl=%b imm=%h wr=%0d sum=%h exp ctrl=%b imm=%h wr=%0d sum=%h",
               name, instruction, reg_data1, reg_data2,
               ctrl_vec(), imm, write_reg, alu_result,
               ec, ei, ew, es);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instruction = 8'h00;
    reg_data1 = 8'h00;
    reg_data2 = 8'h00;
    repeat (3) @(posedge clk_in);
    #1;
    tests_run++;
    if (clk_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_clk_out got %b exp 0", clk_out);
    end
  endtask

  task automatic run_divider(input string name, input int edges);
    logic exp;
    @(negedge clk_in);
    reset = 1'b0;
    for (int n = 1; n <= edges; n++) begin
      @(posedge clk_in);
      #1;
      exp = ((n / HP) % 2) == 1;
      tests_run++;
      if (clk_out !== exp) begin
        tests_failed++;
        $display("FAIL %s edge %0d got %b exp %b",
                 name, n, clk_out, exp);
      end
    end
  endtask

  task automatic test_divider();
    run_divider("divider", 12);
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    @(negedge clk_in);
    run_divider("pre_mid", HP);
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (clk_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_async got %b exp 0", clk_out);
    end
    repeat (3) @(posedge clk_in);
    #1;
    tests_run++;
    if (clk_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold got %b exp 0", clk_out);
    end
    run_divider("post_mid", 6);
  endtask

  task automatic test_decode_sweep();
    logic [7:0] ins_t [4];
    logic [7:0] exp_t [4];
    ins_t[0] = 8'h00; exp_t[0] = 8'b11000001;
    ins_t[1] = 8'h40; exp_t[1] = 8'b01101010;
    ins_t[2] = 8'h80; exp_t[2] = 8'b00100100;
    ins_t[3] = 8'hC0; exp_t[3] = 8'b00010000;
    for (int i = 0; i < 4; i++) begin
      instruction = ins_t[i];
      #1;
      tests_run++;
      if (ctrl_vec() !== exp_t[i]) begin
        tests_failed++;
        $display("FAIL decode ins=%h got %b exp %b",
                 ins_t[i], ctrl_vec(), exp_t[i]);
      end
    end
  endtask

  task automatic test_datapath();
    instruction = 8'h1B;
    reg_data1 = 8'h05;
    reg_data2 = 8'h07;
    #1;
    tests_run++;
    if (alu_result !== 8'h0C || write_reg !== 2'd3) begin
      tests_failed++;
      $display("FAIL add got sum=%h wr=%0d exp 0c/3",
               alu_result, write_reg);
    end
    reg_data1 = 8'hFF;
    reg_data2 = 8'h02;
    #1;
    tests_run++;
    if (alu_result !== 8'h01) begin
      tests_failed++;
      $display("FAIL wrap got %h exp 01", alu_result);
    end
    instruction = 8'h66;
    reg_data1 = 8'h10;
    reg_data2 = 8'hAA;
    #1;
    tests_run++;
    if (imm !== 8'hFE || alu_result !== 8'h0E ||
        write_reg !== 2'd1) begin
      tests_failed++;
      $display("FAIL load_imm got imm=%h sum=%h wr=%0d exp fe/0e/1",
               imm, alu_result, write_reg);
    end
    instruction = 8'hC3;
    #1;
    tests_run++;
    if (imm !== 8'hFF || branch !== 1'b1 ||
        reg_write !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL jump got imm=%h br=%b rw=%b mw=%b exp ff/1/0/0",
               imm, branch, reg_write, mem_write);
    end
    for (int f = 0; f < 4; f++) begin
      instruction = {6'b010000, 2'(f)};
      reg_data1 = 8'h80;
      #1;
      check_comb("imm_field");
    end
  endtask

  task automatic test_in_reset();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instruction = 8'($urandom);
      reg_data1 = 8'($urandom);
      reg_data2 = 8'($urandom);
      #1;
      check_comb("in_reset");
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      instruction = 8'($urandom);
      reg_data1 = 8'($urandom);
      reg_data2 = 8'($urandom);
      #1;
      check_comb("random");
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_reset_mid();
    test_decode_sweep();
    test_datapath();
    test_in_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

endmodule
